// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: default geometry,
// pointer-width helper and the queue entry layout {pc, instr}.
package fetch_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_WIDTH = 32;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int fq_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FQ_PTR_W = fq_ptr_width(FQ_DEPTH);

  typedef struct packed {
    logic [FQ_WIDTH-1:0] pc;
    logic [FQ_WIDTH-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the program counter, an in-order
// instruction memory and the decode stage.
//  - alloc: advances when a request is issued (slot gets its pc)
//  - fill : advances when a response is accepted (slot gets its instr)
//  - read : advances when decode pops an entry
// Credits = DEPTH - (alloc-read) - discard, so every outstanding request
// (including ones orphaned by a flush) always has a slot reserved.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to hand a response straight
// to decode in the same cycle when the queue holds no filled entries.
// Entry fields are FQ_WIDTH wide; WIDTH is expected to be <= FQ_WIDTH.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  output logic             stall_f,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             flush,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc
);

  localparam int PW = fq_ptr_width(DEPTH);
  localparam int IW = PW - 1;

  fq_entry_t        mem_q [DEPTH];

  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    read_q, read_d;
  logic [PW-1:0]    discard_q, discard_d;

  logic [PW-1:0]    inflight_s;
  logic [PW-1:0]    used_s;
  logic             drop_s;
  logic             accept_s;
  logic             bypass_s;
  logic             pop_s;
  logic             store_s;
  logic [IW-1:0]    alloc_idx_s;
  logic [IW-1:0]    fill_idx_s;
  logic [IW-1:0]    read_idx_s;

  assign alloc_idx_s = alloc_q[IW-1:0];
  assign fill_idx_s  = fill_q[IW-1:0];
  assign read_idx_s  = read_q[IW-1:0];

  // Occupancy terms, issue/stall handshake and response classification.
  always_comb begin
    inflight_s = alloc_q - fill_q;
    used_s     = (alloc_q - read_q) + discard_q;
    imem_req   = !rst && !flush && (used_s < PW'(DEPTH));
    stall_f    = !rst && !imem_req && !flush;
    imem_addr  = pc_f;
    drop_s     = imem_rvalid && (discard_q != {PW{1'b0}});
    accept_s   = imem_rvalid && (discard_q == {PW{1'b0}}) && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s   = accept_s && (fill_q == read_q);
`else
    bypass_s   = 1'b0;
`endif
  end

  // Decode-side view: head slot, or the live response when bypassing.
  always_comb begin
    dec_valid = 1'b0;
    dec_instr = {WIDTH{1'b0}};
    dec_pc    = {WIDTH{1'b0}};
    if (rst) begin
      dec_valid = 1'b0;
    end else begin
      dec_valid = (fill_q != read_q) || bypass_s;
      dec_pc    = WIDTH'(mem_q[read_idx_s].pc);
      if (bypass_s) begin
        dec_instr = imem_rdata;
      end else begin
        dec_instr = WIDTH'(mem_q[read_idx_s].instr);
      end
    end
    pop_s   = dec_valid && dec_ready;
    // A bypassed word consumed by decode never needs a slot.
    store_s = accept_s && !(bypass_s && dec_ready);
  end

  // Next-state for pointers and the owed-response counter.
  always_comb begin
    alloc_d   = alloc_q;
    fill_d    = fill_q;
    read_d    = read_q;
    discard_d = discard_q;
    if (flush) begin
      alloc_d   = {PW{1'b0}};
      fill_d    = {PW{1'b0}};
      read_d    = {PW{1'b0}};
      // A response arriving this cycle settles one of the owed requests.
      discard_d = inflight_s + discard_q - (imem_rvalid ? PW'(1) : PW'(0));
    end else begin
      if (imem_req) begin
        alloc_d = alloc_q + PW'(1);
      end else begin
        alloc_d = alloc_q;
      end
      if (accept_s) begin
        fill_d = fill_q + PW'(1);
      end else begin
        fill_d = fill_q;
      end
      if (pop_s) begin
        read_d = read_q + PW'(1);
      end else begin
        read_d = read_q;
      end
      if (drop_s) begin
        discard_d = discard_q - PW'(1);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Pointer and discard state; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q   <= {PW{1'b0}};
      fill_q    <= {PW{1'b0}};
      read_q    <= {PW{1'b0}};
      discard_q <= {PW{1'b0}};
    end else begin
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      read_q    <= read_d;
      discard_q <= discard_d;
    end
  end

  // Entry storage: pc written at issue, instr written at response; data-only,
  // validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (imem_req) begin
      mem_q[alloc_idx_s].pc <= FQ_WIDTH'(pc_f);
    end
    if (store_s) begin
      mem_q[fill_idx_s].instr <= FQ_WIDTH'(imem_rdata);
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction and address width.
REQ-002 SHALL have parameter DEPTH, default 4, number of queue entries (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port pc_f, input, WIDTH, current fetch address from the program counter output.
REQ-006 SHALL have port stall_f, output, 1, fetch stall that drives the program counter StallF.
REQ-007 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-008 SHALL have port imem_addr, output, WIDTH, request address, equal to pc_f.
REQ-009 SHALL have port imem_rvalid, input, 1, in-order read response valid; latency >=1 cycle.
REQ-010 SHALL have port imem_rdata, input, WIDTH, response instruction.
REQ-011 SHALL have port flush, input, 1, redirect: discard queued and in-flight fetches.
REQ-012 SHALL have ports dec_valid (output, 1), dec_ready (input, 1), dec_instr (output, WIDTH), dec_pc (output, WIDTH), decode-side valid/ready handshake.

Function
REQ-013 SHALL keep three pointers, alloc, fill and read, each log2(DEPTH)+1 bits wide and wrapping modulo 2*DEPTH: alloc advances on issue, fill on an accepted response, read on pop.
REQ-014 SHALL hold a discard counter, 0..DEPTH, of responses still owed for flushed requests.
REQ-015 SHALL assert imem_req = !rst && !flush && ((alloc-read)+discard < DEPTH), combinationally.
REQ-016 SHALL, on issue, store pc_f in slot alloc and advance alloc.
REQ-017 SHALL drive stall_f = !imem_req && !flush, so the PC advances only when its address was issued and on a flush cycle.
REQ-018 SHALL, on imem_rvalid with discard>0, drop the data and decrement discard.
REQ-019 SHALL, on imem_rvalid with discard=0 and no flush, write imem_rdata into slot fill and advance fill.
REQ-020 SHALL drive dec_valid = (fill != read), with dec_instr and dec_pc taken from slot read.
REQ-021 SHALL pop the entry when dec_valid && dec_ready, advancing read.
REQ-022 SHALL, on flush, set alloc, fill and read to 0 and set discard to (alloc-fill)+discard-(imem_rvalid?1:0).
REQ-023 SHALL assert dec_valid=0 in the cycle after a flush.
REQ-024 SHALL allow issue, response and pop in the same cycle.
REQ-025 SHALL stall with imem_req=0 and stall_f=1 when full ((alloc-read)+discard = DEPTH), and issue again in the cycle after a pop frees a credit.

Reset
REQ-026 SHALL, while rst is high, clear alloc, fill, read and discard to 0 and force dec_valid=0, imem_req=0, stall_f=0, dec_instr=0 and dec_pc=0.
REQ-027 SHALL discard any in-flight response outstanding at reset assertion: the memory is reset together with this block.

Configuration
REQ-028 SHALL, with FETCH_QUEUE_BYPASS_EN defined, pass a response directly to decode when fill==read, imem_rvalid=1, discard=0 and no flush: dec_valid=1, dec_instr=imem_rdata, dec_pc taken from slot read, in the same cycle.
REQ-029 SHALL, in that bypass case with dec_ready=1, advance fill and read together and not store the data.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, have a minimum latency of 1 cycle from imem_rvalid to dec_valid.

Structure
REQ-031 SHALL take DEPTH default, pointer-width constant and the entry typedef {pc, instr} from shared package fetch_pkg.
REQ-032 SHALL need no sub-module: the storage is an inline register array; no RAM macro.

Verification
REQ-033 Reset then 1-cycle memory, dec_ready=1, pc_f 0,4,8: dec_pc 0,4,8 with matching dec_instr on consecutive cycles; stall_f=0 throughout.
REQ-034 dec_ready=0, DEPTH=4: after 4 issues, imem_req=0 and stall_f=1; one pop then gives imem_req=1 in the next cycle.
REQ-035 Flush with 2 requests in flight: the next 2 imem_rvalid are dropped; the first dec_valid carries the redirect pc_f (e.g. 0x100).
REQ-036 Flush in the same cycle as imem_rvalid and a pop: discard = outstanding-1; queue empty next cycle.
REQ-037 rst asserted mid-stream with 3 entries valid: dec_valid=0 immediately; after release, fetch restarts at pc_f=0.
REQ-038 With FETCH_QUEUE_BYPASS_EN on an empty queue: imem_rvalid with rdata 0x00500093 gives dec_valid=1 and dec_instr=0x00500093 in the same cycle; without the macro, one cycle later.
